// File: rtl/element_serializer_pkg.sv
// Shared definitions for the XML element serializer and its name table:
// bus widths, tag/key codes, punctuation characters, FSM state encoding
// and a helper that picks one character out of a packed name.
package element_serializer_pkg;

    localparam int CHAR_BITES           = 8;
    localparam int ELE_TAG_BITES        = 3;
    localparam int ATTRIBUTE_TYPE_BITES = 2;
    localparam int ATTRIBUTE_VAL_CHARS  = 8;
    localparam int MAX_NAME             = 5;
    localparam int NAME_LEN_BITES       = 3;
    localparam int INDEX_BITES          = 3;

    // Element tag codes
    localparam logic [ELE_TAG_BITES-1:0] TAG_DIV  = 3'd0;
    localparam logic [ELE_TAG_BITES-1:0] TAG_P    = 3'd1;
    localparam logic [ELE_TAG_BITES-1:0] TAG_BODY = 3'd2;
    localparam logic [ELE_TAG_BITES-1:0] TAG_A    = 3'd3;
    localparam logic [ELE_TAG_BITES-1:0] TAG_IMG  = 3'd4;

    // Attribute key codes
    localparam logic [ATTRIBUTE_TYPE_BITES-1:0] KEY_ID    = 2'd0;
    localparam logic [ATTRIBUTE_TYPE_BITES-1:0] KEY_CLASS = 2'd1;
    localparam logic [ATTRIBUTE_TYPE_BITES-1:0] KEY_HREF  = 2'd2;
    localparam logic [ATTRIBUTE_TYPE_BITES-1:0] KEY_SRC   = 2'd3;

    // Punctuation
    localparam logic [CHAR_BITES-1:0] CH_NUL   = 8'h00;
    localparam logic [CHAR_BITES-1:0] CH_SP    = 8'h20;
    localparam logic [CHAR_BITES-1:0] CH_QUOTE = 8'h22;
    localparam logic [CHAR_BITES-1:0] CH_SLASH = 8'h2F;
    localparam logic [CHAR_BITES-1:0] CH_LT    = 8'h3C;
    localparam logic [CHAR_BITES-1:0] CH_EQ    = 8'h3D;
    localparam logic [CHAR_BITES-1:0] CH_GT    = 8'h3E;

    typedef enum logic [3:0] {
        S_IDLE, S_LT, S_SLASH, S_TAG, S_AWAIT, S_SP,
        S_KEY, S_EQ, S_QO, S_VAL, S_QC, S_GT
    } state_t;

    // Names are stored right-justified (first character in the highest
    // occupied byte), so character 'index' sits at byte (len-1-index).
    function automatic logic [CHAR_BITES-1:0] name_char(
        input logic [MAX_NAME*CHAR_BITES-1:0] name,
        input logic [NAME_LEN_BITES-1:0]      len,
        input logic [INDEX_BITES-1:0]         index
    );
        logic [NAME_LEN_BITES-1:0] pos;
        pos = len - 3'd1 - index;
        return name[32'(pos) * CHAR_BITES +: CHAR_BITES];
    endfunction

endpackage

// File: rtl/element_serializer_name_rom.sv
// Combinational name table shared by serializer and parser sides.
// Ports:
//   is_attr   - 0 selects the tag table, 1 the attribute-key table
//   code      - tag code, or key code in the low bits when is_attr=1
//   index     - character position within the name
//   character - ASCII character at that position
//   length    - number of characters in the selected name
module element_serializer_name_rom
    import element_serializer_pkg::*;
(
    input  logic                      is_attr,
    input  logic [ELE_TAG_BITES-1:0]  code,
    input  logic [INDEX_BITES-1:0]    index,
    output logic [CHAR_BITES-1:0]     character,
    output logic [NAME_LEN_BITES-1:0] length
);

    logic [MAX_NAME*CHAR_BITES-1:0] name;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        name   = {16'h0, "div"};
        length = 3'd3;
        if (is_attr) begin
            unique case (code[ATTRIBUTE_TYPE_BITES-1:0])
                KEY_ID:    begin name = {24'h0, "id"};  length = 3'd2; end
                KEY_CLASS: begin name = "class";        length = 3'd5; end
                KEY_HREF:  begin name = {8'h0, "href"}; length = 3'd4; end
                KEY_SRC:   begin name = {16'h0, "src"}; length = 3'd3; end
            endcase
        end else begin
            case (code)
                TAG_P:    begin name = {32'h0, "p"};    length = 3'd1; end
                TAG_BODY: begin name = {8'h0, "body"};  length = 3'd4; end
                TAG_A:    begin name = {32'h0, "a"};    length = 3'd1; end
                TAG_IMG:  begin name = {16'h0, "img"};  length = 3'd3; end
                // TAG_DIV and the unassigned codes 5..7 all render as "div"
                default:  begin name = {16'h0, "div"};  length = 3'd3; end
            endcase
        end
        character = name_char(name, length, index);
    end

endmodule

// File: rtl/element_serializer.sv
// Turns a decoded XML element (tag, start/end, attribute key/value pairs)
// into a character stream such as <a href="x.htm"> or </div>.
// Ports:
//   clock, reset_n          - clock, asynchronous active-low reset
//   start, element_tag,
//   element_type, has_attrs - element request, sampled while idle
//   busy                    - element in progress
//   attr_valid/attr_ready,
//   attr_type, attr_value,
//   attr_last               - attribute handshake; value is NUL-terminated, char 0 in LSBs
//   char_out/char_valid/
//   char_ready              - output character handshake
//   done                    - one-cycle pulse after '>' is accepted
module element_serializer
    import element_serializer_pkg::*;
#(
    parameter int CHAR_W      = CHAR_BITES,
    parameter int TAG_W       = ELE_TAG_BITES,
    parameter int ATTR_TYPE_W = ATTRIBUTE_TYPE_BITES,
    parameter int VAL_CHARS   = ATTRIBUTE_VAL_CHARS
)(
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [TAG_W-1:0]            element_tag,
    input  logic                        element_type,
    input  logic                        has_attrs,
    output logic                        busy,
    input  logic                        attr_valid,
    output logic                        attr_ready,
    input  logic [ATTR_TYPE_W-1:0]      attr_type,
    input  logic [VAL_CHARS*CHAR_W-1:0] attr_value,
    input  logic                        attr_last,
    output logic [CHAR_W-1:0]           char_out,
    output logic                        char_valid,
    input  logic                        char_ready,
    output logic                        done
);

    state_t                      state_q, state_d;
    logic [INDEX_BITES-1:0]      idx_q, idx_d, idx_inc;
    logic [TAG_W-1:0]            tag_q;
    logic                        end_q, attrs_q, last_q, done_q;
    logic [ATTR_TYPE_W-1:0]      key_q;
    logic [VAL_CHARS*CHAR_W-1:0] value_q;
    logic [CHAR_W-1:0]           rom_char, cur_val_char, nxt_val_char;
    logic [NAME_LEN_BITES-1:0]   rom_len;
    logic                        fire;

    element_serializer_name_rom u_name_rom (
        .is_attr   (state_q == S_KEY),
        .code      ((state_q == S_KEY) ? ELE_TAG_BITES'(key_q) : ELE_TAG_BITES'(tag_q)),
        .index     (idx_q),
        .character (rom_char),
        .length    (rom_len)
    );

    assign idx_inc      = idx_q + 3'd1;
    assign cur_val_char = value_q[32'(idx_q)   * CHAR_W +: CHAR_W];
    assign nxt_val_char = value_q[32'(idx_inc) * CHAR_W +: CHAR_W];

    // Every state except IDLE and AWAIT presents a character.
    assign char_valid = (state_q != S_IDLE) && (state_q != S_AWAIT);
    assign fire       = char_valid && char_ready;
    assign busy       = (state_q != S_IDLE);
    assign attr_ready = (state_q == S_AWAIT);
    assign done       = done_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        char_out = '0;
        case (state_q)
            S_IDLE:  if (start) begin state_d = S_LT; idx_d = '0; end
            S_LT: begin
                char_out = CH_LT;
                if (fire) state_d = end_q ? S_SLASH : S_TAG;
            end
            S_SLASH: begin
                char_out = CH_SLASH;
                if (fire) state_d = S_TAG;
            end
            S_TAG: begin
                char_out = rom_char;
                if (fire) begin
                    if (idx_q == rom_len - 3'd1) begin
                        idx_d = '0;
                        // End tags never carry attributes, whatever has_attrs said
                        state_d = (attrs_q && !end_q) ? S_AWAIT : S_GT;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_AWAIT: if (attr_valid) state_d = S_SP;
            S_SP: begin
                char_out = CH_SP;
                if (fire) state_d = S_KEY;
            end
            S_KEY: begin
                char_out = rom_char;
                if (fire) begin
                    if (idx_q == rom_len - 3'd1) begin
                        idx_d   = '0;
                        state_d = S_EQ;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_EQ: begin
                char_out = CH_EQ;
                if (fire) state_d = S_QO;
            end
            S_QO: begin
                char_out = CH_QUOTE;
                // An empty value skips VAL entirely and yields key=""
                if (fire) state_d = (value_q[CHAR_W-1:0] == CH_NUL) ? S_QC : S_VAL;
            end
            S_VAL: begin
                char_out = cur_val_char;
                if (fire) begin
                    if (idx_q == INDEX_BITES'(VAL_CHARS - 1) || nxt_val_char == CH_NUL) begin
                        idx_d   = '0;
                        state_d = S_QC;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_QC: begin
                char_out = CH_QUOTE;
                if (fire) state_d = last_q ? S_GT : S_AWAIT;
            end
            S_GT: begin
                char_out = CH_GT;
                if (fire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tag_q   <= '0;
            end_q   <= 1'b0;
            attrs_q <= 1'b0;
            key_q   <= '0;
            // NOTE: the value register is reset as well; it is a handful of flops, not a RAM, and a known value keeps reruns deterministic.
            value_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= (state_q == S_GT) && char_ready;
            if (state_q == S_IDLE && start) begin
                tag_q   <= element_tag;
                end_q   <= element_type;
                attrs_q <= has_attrs;
            end
            if (state_q == S_AWAIT && attr_valid) begin
                key_q   <= attr_type;
                value_q <= attr_value;
                last_q  <= attr_last;
            end
        end
    end

endmodule

// File: tb/tb_element_serializer.sv
// Directed self-checking bench for element_serializer: drives elements and
// attributes, collects the accepted character stream and compares it with
// hand-written expected strings.
module tb_element_serializer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  element_tag;
    logic        element_type;
    logic        has_attrs;
    logic        busy;
    logic        attr_valid;
    logic        attr_ready;
    logic [1:0]  attr_type;
    logic [63:0] attr_value;
    logic        attr_last;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0]  a_type [4];
    logic [63:0] a_val  [4];

    element_serializer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .element_tag  (element_tag),
        .element_type (element_type),
        .has_attrs    (has_attrs),
        .busy         (busy),
        .attr_valid   (attr_valid),
        .attr_ready   (attr_ready),
        .attr_type    (attr_type),
        .attr_value   (attr_value),
        .attr_last    (attr_last),
        .char_out     (char_out),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] pack(input string s);
        logic [63:0] v = '0;
        for (int i = 0; i < s.len() && i < 8; i++) v[i*8 +: 8] = s[i];
        return v;
    endfunction

    // Runs one element from start to the done pulse. Called at #1 after an
    // edge; returns at #1 in the done cycle so a following call presents
    // start back-to-back in that cycle.
    task automatic run_element(input string name, input logic [2:0] tag, input logic typ,
                               input logic ha, input int na, input bit stall,
                               input bit poke, input string exp);
        logic [7:0] got_chars [64];
        logic [7:0] prev_c = '0;
        bit         prev_stall = 0;
        bit         rdy;
        int n = 0, ai = 0, cyc = 0, gt_cyc = -1, done_cyc = -1;
        int gaps = 0, ar_seen = 0, hold_err = 0;

        element_tag = tag; element_type = typ; has_attrs = ha; start = 1'b1;
        step();
        start = 1'b0;
        check({name, "_busy_after_start"}, busy, 1);
        check({name, "_lt_valid"}, char_valid, 1);
        check({name, "_lt_char"}, char_out, 8'h3C);
        check({name, "_done_low"}, done, 0);

        while (done_cyc < 0 && cyc < 400) begin
            if (done) begin
                done_cyc = cyc;
                check({name, "_busy_at_done"}, busy, 0);
            end else begin
                if (prev_stall && (!char_valid || char_out !== prev_c)) hold_err++;
                if (busy && !char_valid && !attr_ready) gaps++;
                if (attr_ready) ar_seen++;
                attr_valid = 1'b0;
                if (attr_ready && ai < na) begin
                    attr_type  = a_type[ai];
                    attr_value = a_val[ai];
                    attr_last  = (ai == na - 1);
                    attr_valid = 1'b1;
                    ai++;
                end
                rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                char_ready = rdy;
                if (char_valid && rdy) begin
                    if (n < 64) got_chars[n] = char_out;
                    if (char_out == 8'h3E) gt_cyc = cyc;
                    n++;
                end
                prev_stall = char_valid && !rdy;
                prev_c     = char_out;
                if (poke && cyc == 2) begin
                    start = 1'b1; element_tag = 3'd2; element_type = ~typ;
                end else begin
                    start = 1'b0; element_tag = tag; element_type = typ;
                end
                step();
                cyc++;
            end
        end
        char_ready = 1'b1;
        attr_valid = 1'b0;
        start      = 1'b0;

        check({name, "_done_seen"}, done_cyc >= 0, 1);
        check({name, "_len"}, n, exp.len());
        for (int i = 0; i < exp.len(); i++)
            check($sformatf("%s_char%0d", name, i), (i < n && i < 64) ? got_chars[i] : 8'h00, exp[i]);
        check({name, "_done_latency"}, done_cyc, gt_cyc + 1);
        check({name, "_gaps"}, gaps, 0);
        check({name, "_stall_hold"}, hold_err, 0);
        check({name, "_attrs_taken"}, ai, na);
        if (!(ha && !typ)) check({name, "_no_attr_ready"}, ar_seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset_n = 1'b0; start = 1'b0; element_tag = '0; element_type = 1'b0;
        has_attrs = 1'b0; attr_valid = 1'b0; attr_type = '0; attr_value = '0;
        attr_last = 1'b0; char_ready = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_attr_ready", attr_ready, 0);
        check("rst_char_valid", char_valid, 0);
        check("rst_char_out", char_out, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // Back-to-back: second and third starts land in the done cycle of the previous one
        run_element("p",        3'd1, 1'b0, 1'b0, 0, 0, 0, "<p>");
        run_element("end_div",  3'd0, 1'b1, 1'b0, 0, 0, 0, "</div>");
        run_element("end_attr", 3'd0, 1'b1, 1'b1, 0, 0, 0, "</div>");

        a_type[0] = 2'd2; a_val[0] = pack("x.htm");
        run_element("a_href",   3'd3, 1'b0, 1'b1, 1, 0, 0, "<a href=\"x.htm\">");

        a_type[0] = 2'd3; a_val[0] = pack("i.png");
        a_type[1] = 2'd0; a_val[1] = 64'h0;
        run_element("img",      3'd4, 1'b0, 1'b1, 2, 0, 0, "<img src=\"i.png\" id=\"\">");

        a_type[0] = 2'd1; a_val[0] = pack("abcdefgh");
        run_element("body_stall", 3'd2, 1'b0, 1'b1, 1, 1, 1, "<body class=\"abcdefgh\">");

        run_element("tag6",     3'd6, 1'b0, 1'b0, 0, 0, 0, "<div>");

        // Reset in the middle of the attribute value
        a_type[0] = 2'd2; a_val[0] = pack("x.htm");
        element_tag = 3'd3; element_type = 1'b0; has_attrs = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 10; k++) begin
            attr_valid = attr_ready;
            attr_type  = a_type[0];
            attr_value = a_val[0];
            attr_last  = 1'b1;
            char_ready = 1'b1;
            if (char_valid) cnt++;
            step();
        end
        attr_valid = 1'b0;
        check("rst_mid_pre_valid", char_valid, 1);
        check("rst_mid_pre_char", char_out, 8'h2E);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_char_valid", char_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_char_out", char_out, 0);
        check("rst_mid_attr_ready", attr_ready, 0);
        check("rst_mid_done", done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        run_element("p_after_rst", 3'd1, 1'b0, 1'b0, 0, 0, 0, "<p>");
        step();
        check("final_done_drop", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
